// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types and ALU evaluation for alu_rr_scheduler
package alu_sched_pkg;

  localparam int unsigned ALU_MAXW = 64;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    FLAG_NEG   = 2'd0,
    FLAG_ZERO  = 2'd1,
    FLAG_CARRY = 2'd2,
    FLAG_OVF   = 2'd3
  } flag_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } sched_state_e;

  typedef struct packed {
    logic [3:0]          flags;
    logic [ALU_MAXW-1:0] result;
  } alu_out_t;

  // Evaluates at runtime width w (1..ALU_MAXW); operands above w are masked off.
  function automatic alu_out_t alu_eval(input alu_op_e op,
                                        input logic [ALU_MAXW-1:0] a,
                                        input logic [ALU_MAXW-1:0] b,
                                        input int unsigned w);
    logic [ALU_MAXW-1:0] mask;
    logic [ALU_MAXW-1:0] bx;
    logic [ALU_MAXW-1:0] res;
    logic [ALU_MAXW:0]   sum;
    logic [6:0]          cidx;
    logic [5:0]          midx;
    logic                cin;
    alu_out_t            o;
    mask = (w >= ALU_MAXW) ? '1 : ((ALU_MAXW'(1) << w) - ALU_MAXW'(1));
    cidx = 7'(w);
    midx = 6'(w - 1);
    cin  = (op == OP_SUB);
    bx   = cin ? (~b & mask) : (b & mask);
    sum  = {1'b0, a & mask} + {1'b0, bx} + {{ALU_MAXW{1'b0}}, cin};
    o.flags = '0;
    case (op)
      OP_AND:  res = a & b & mask;
      OP_OR:   res = (a | b) & mask;
      default: begin
        res = sum[ALU_MAXW-1:0] & mask;
        o.flags[FLAG_CARRY] = sum[cidx];
        o.flags[FLAG_OVF]   = (a[midx] == bx[midx]) && (res[midx] != a[midx]);
      end
    endcase
    o.flags[FLAG_NEG]  = res[midx];
    o.flags[FLAG_ZERO] = (res == '0);
    o.result = res;
    return o;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter starting its search at ptr_i
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_req_o
);

  logic [IW-1:0] idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_req_o   = 1'b0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr_i) + k) % N);
      if (!any_req_o && req_i[idx]) begin
        any_req_o    = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin shared ALU scheduler; ALU_RR_SCHED_STATS_EN adds grant_count
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 32,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [3:0]            rsp_flags,
`ifdef ALU_RR_SCHED_STATS_EN
  output logic [NREQ*16-1:0]    grant_count,
`endif
  output logic                  busy
);

  sched_state_e     state_q;
  logic [IDW-1:0]   rr_ptr_q;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDW-1:0]   id_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [3:0]       rsp_flags_q;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             any_req;
  logic [IDW-1:0]   rr_ptr_d;
  alu_out_t         alu_res;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_req_o   (any_req)
  );

  assign rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : IDW'(grant_idx + 1'b1);
  assign alu_res  = alu_eval(op_q, ALU_MAXW'(a_q), ALU_MAXW'(b_q), WIDTH);

  // Gated by rst_n so no requester sees an accept while reset is held.
  assign req_ready  = (rst_n && state_q == ST_IDLE) ? grant : '0;
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (any_req) begin
          op_q     <= alu_op_e'(req_op[2*grant_idx +: 2]);
          a_q      <= req_a[grant_idx*WIDTH +: WIDTH];
          b_q      <= req_b[grant_idx*WIDTH +: WIDTH];
          id_q     <= grant_idx;
          rr_ptr_q <= rr_ptr_d;
          state_q  <= ST_EXEC;
        end
        ST_EXEC: begin
          rsp_result_q <= alu_res.result[WIDTH-1:0];
          rsp_flags_q  <= alu_res.flags;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_RR_SCHED_STATS_EN
  logic [15:0] cnt_q [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (state_q == ST_IDLE && any_req && cnt_q[grant_idx] != 16'hFFFF) begin
      cnt_q[grant_idx] <= cnt_q[grant_idx] + 16'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign grant_count[16*g +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one 32-bit ADD/SUB/AND/OR ALU with NZCV flags between NREQ requesters.
- Uses round-robin arbitration and a valid/ready handshake on each request port.
- Latches the winner's operands, executes one operation, and returns result, flags and requester ID on a single response channel with backpressure.
- Sits between requesting engines and the shared arithmetic datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width.
- IDW, $clog2(NREQ), requester ID width (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_op  in  NREQ*2  per-requester opcode; slice i = [2i+1:2i].
- req_a  in  NREQ*WIDTH  per-requester operand A.
- req_b  in  NREQ*WIDTH  per-requester operand B.
- req_ready  out  NREQ  one-hot accept strobe.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the served requester.
- rsp_result  out  WIDTH  ALU result.
- rsp_flags  out  4  {V,C,Z,N}; bit0=N, bit1=Z, bit2=C, bit3=V.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, busy=0.
  - req_ready=0 (combinational off state).
- Opcodes: ADD=2'b00, SUB=2'b01, AND=2'b10, OR=2'b11.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod NREQ.
  - req_ready[grant]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On that edge: latch op/a/b/id, rr_ptr <= (grant+1) mod NREQ, go to EXEC.
  - No valid request: stay in IDLE, rr_ptr unchanged.
- EXEC:
  - ALU evaluates the latched operands.
  - On the edge: register result/flags/id, set rsp_valid=1, go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On an edge with rsp_ready=1: rsp_valid<=0, go to IDLE.
  - rsp_result, rsp_flags and rsp_id keep their last values after the handshake.
- Latency: accept at edge T, rsp_valid high after edge T+1. Minimum 3 cycles per operation.
- Requesters must hold req_* stable until req_ready; operands are sampled only on the accept edge.
- A request dropped before acceptance is legal. The arbiter ignores it.
- Arithmetic, all unsigned modulo 2^WIDTH:
  - ADD: sum = a + b.
  - SUB: sum = a + ~b + 1.
  - C = carry-out of the WIDTH-bit add. For SUB, C=1 means no borrow (a>=b unsigned).
  - V = (a[msb] == b'[msb]) && (sum[msb] != a[msb]), where b' = b for ADD and ~b for SUB.
  - AND/OR: C=0, V=0.
  - All ops: N=result[msb], Z=(result==0).
- Simultaneous requests: exactly one grant per IDLE cycle. With continuous requests from all ports, grant order is 0,1,2,3,0,…
- Reset mid-operation: the in-flight operation is discarded, no response is emitted, and the arbiter restarts from IDLE with rr_ptr=0.
- Out-of-range or X opcode is not possible (2 bits, all legal).

Optional Feature:
- Macro: ALU_RR_SCHED_STATS_EN.
- Defined: adds output port grant_count (NREQ*16 bits), one saturating 16-bit counter per requester.
  - A counter increments on each accept edge for its requester and saturates at 16'hFFFF.
  - All counters reset to 0.
- Undefined: no port, no counters. All other behaviour is identical.

Decomposition:
- Package alu_sched_pkg holds:
  - alu_op_e enum (ADD/SUB/AND/OR, 2-bit).
  - flag index enum (NEG=0, ZERO=1, CARRY=2, OVF=3).
  - sched_state_e enum (IDLE/EXEC/RESP).
  - Function alu_eval(op, a, b) returning {flags, result}.
- Sub-module rr_arbiter (parameter N): inputs req vector and ptr; outputs one-hot grant, grant index and any_req. Purely combinational.
- The FSM and datapath registers live in alu_rr_scheduler.

Test Plan:
- Single request, ADD: port 2, a=32'h7FFF_FFFF, b=1.
  - req_ready[2] pulses 1 cycle, rsp_valid 2 cycles later.
  - result=32'h8000_0000, id=2, flags N=1 Z=0 C=0 V=1.
- SUB equal operands: port 0, a=b=32'h0000_1234.
  - result=0, flags Z=1 C=1 N=0 V=0.
- SUB borrow: port 1, a=0, b=1.
  - result=32'hFFFF_FFFF, N=1 C=0 V=0.
- AND/OR on port 3:
  - AND 32'hF0F0_F0F0 & 32'h0FF0_0FF0 gives 32'h00F0_00F0, C=V=0.
  - OR of 0 and 0 gives result 0, Z=1.
- Fairness: all 4 ports request continuously with rsp_ready=1.
  - Grant sequence is 0,1,2,3,0,1, each spaced 3 cycles.
  - rsp_id matches the grant sequence.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles: rsp_* stay stable, req_ready stays 0, busy=1.
  - Assert rst_n=0 in EXEC: rsp_valid=0 immediately, busy=0, and the next grant goes to port 0.
